// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_arb_pkg
// Brief    : Shared types and default sizing for the register write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package reg_arb_pkg;

    localparam int c_NREQ_DEFAULT  = 4;
    localparam int c_WIDTH_DEFAULT = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage : reg_arb_pkg
`default_nettype wire

// File: rtl/reg_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; first eligible index at or
//            above ptr, wrapping from NREQ-1 back to 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = c_NREQ_DEFAULT,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner,
    output logic [PTR_W-1:0] index,
    output logic             valid
);

    logic [PTR_W:0] w_cand;

    always_comb begin
        winner = '0;
        index  = '0;
        valid  = 1'b0;
        w_cand = '0;
        for (int i = 0; i < NREQ; i++) begin
            // One spare bit so ptr+i can exceed NREQ-1 before the modulo fold.
            w_cand = {1'b0, ptr} + (PTR_W+1)'(i);
            if (w_cand >= (PTR_W+1)'(NREQ)) begin
                w_cand = w_cand - (PTR_W+1)'(NREQ);
            end
            if (!valid && eligible[w_cand[PTR_W-1:0]]) begin
                valid                      = 1'b1;
                index                      = w_cand[PTR_W-1:0];
                winner[w_cand[PTR_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/reg_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_wr_arbiter
// Brief    : Round-robin arbiter granting NREQ requesters write access to one
//            shared register; two cycles per write (IDLE -> GRANT).
// Revision : 1.0 - initial release
// ============================================================================
module reg_wr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = c_NREQ_DEFAULT,
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic                  busy
);

    localparam int PTR_W = $clog2(NREQ);

    arb_state_t       r_state;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_ack;
    logic [WIDTH-1:0] r_q;
    logic [PTR_W-1:0] r_ptr;

    logic [NREQ-1:0]  w_eligible;
    logic [NREQ-1:0]  w_win_oh;
    logic [PTR_W-1:0] w_unused_win_idx;
    logic             w_win_valid;
    logic [WIDTH-1:0] w_gnt_lane;
    logic [PTR_W-1:0] w_gnt_idx;
    logic             w_gnt_req;

    // A requester acked this cycle is masked so it cannot be re-granted at once.
    assign w_eligible = req & ~r_ack;

    // The grant is kept one-hot, so the picker's index output is not needed.
    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .eligible (w_eligible),
        .ptr      (r_ptr),
        .winner   (w_win_oh),
        .index    (w_unused_win_idx),
        .valid    (w_win_valid)
    );

    always_comb begin
        w_gnt_lane = '0;
        w_gnt_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_gnt_lane = wdata[i*WIDTH +: WIDTH];
                w_gnt_idx  = PTR_W'(i);
            end
        end
    end

    assign w_gnt_req = |(req & r_gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_q     <= '0;
            r_ptr   <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    r_gnt <= w_win_oh;
                    if (w_win_valid) begin
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    r_gnt   <= '0;
                    r_state <= IDLE;
                    // A dropped request aborts: no write, no ack, ptr held.
                    if (w_gnt_req) begin
                        r_q   <= w_gnt_lane;
                        r_ack <= r_gnt;
                        r_ptr <= (w_gnt_idx == PTR_W'(NREQ-1)) ? '0 : w_gnt_idx + PTR_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign ack  = r_ack;
    assign q    = r_q;
    assign busy = (r_state == GRANT);

endmodule : reg_wr_arbiter
`default_nettype wire

// File: tb/tb_reg_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_wr_arbiter
// Brief    : Directed, scoreboard-checked bench for reg_wr_arbiter (4 x 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic                  busy;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    reg_wr_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [7:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic set_lane(input int idx, input logic [7:0] data);
        wdata[idx*WIDTH +: WIDTH] = data;
    endtask

    // Output monitor: every ack is matched against the next expected write.
    always @(posedge clk) begin
        exp_t e;
        logic [3:0] onehot;
        #1;
        chk("busy_vs_gnt", {31'd0, busy}, {31'd0, |gnt});
        chk("gnt_ack_excl", {31'd0, (|gnt) && (|ack)}, 32'd0);
        if (ack !== '0) begin
            if (sb.size() == 0) begin
                chk("ack_unexpected", {28'd0, ack}, 32'd0);
            end else begin
                e      = sb.pop_front();
                onehot = 4'b0001 << e.idx;
                chk("ack_onehot", {28'd0, ack}, {28'd0, onehot});
                chk("q_write", {24'd0, q}, {24'd0, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        req   = 4'b1111;
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};

        // Reset holds everything low even with all requesters asking.
        repeat (2) begin
            cyc();
            chk("rst_q",    {24'd0, q},   32'd0);
            chk("rst_gnt",  {28'd0, gnt}, 32'd0);
            chk("rst_ack",  {28'd0, ack}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        rst = 1'b0;

        // Round robin with all requesting: grant every other cycle, 0,1,2,3,0.
        push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k % 2 == 1) chk("rr_gnt", {28'd0, gnt}, 32'd1 << (((k - 1) / 2) % 4));
            else            chk("rr_gnt_idle", {28'd0, gnt}, 32'd0);
        end
        req = 4'b0000;

        // Single write by requester 2; other lanes/requests wiggle during GRANT.
        cyc();
        req = 4'b0100;
        set_lane(2, 8'hA5);
        push(2, 8'hA5);
        cyc();
        chk("single_gnt", {28'd0, gnt}, 32'h4);
        req = 4'b1100;
        set_lane(0, 8'hEE);
        cyc();
        chk("single_gnt_off", {28'd0, gnt}, 32'h0);
        chk("single_q", {24'd0, q}, 32'hA5);
        req = 4'b0000;

        // Wrap from ptr 3: requester 0 then 1, never 3.
        set_lane(0, 8'h20);
        set_lane(1, 8'h21);
        req = 4'b0011;
        push(0, 8'h20); push(1, 8'h21);
        cyc();
        chk("wrap_gnt0", {28'd0, gnt}, 32'h1);
        cyc();
        req = 4'b0010;
        cyc();
        chk("wrap_gnt1", {28'd0, gnt}, 32'h2);
        cyc();
        req = 4'b0000;

        // Requester 2 writes, moving ptr to 3.
        set_lane(2, 8'h42);
        set_lane(3, 8'h43);
        req = 4'b1100;
        push(2, 8'h42);
        cyc();
        chk("w2_gnt", {28'd0, gnt}, 32'h4);
        cyc();
        req = 4'b0000;

        // Abort: requester 1 withdraws while granted.
        set_lane(1, 8'h77);
        req = 4'b0010;
        cyc();
        chk("abort_gnt", {28'd0, gnt}, 32'h2);
        req = 4'b0000;
        cyc();
        chk("abort_ack", {28'd0, ack}, 32'h0);
        chk("abort_q", {24'd0, q}, 32'h42);
        chk("abort_busy", {31'd0, busy}, 32'h0);

        // ptr must still be 3, so requester 0 wins over 2.
        set_lane(0, 8'h50);
        set_lane(2, 8'h52);
        req = 4'b0101;
        push(0, 8'h50);
        cyc();
        chk("post_abort_gnt", {28'd0, gnt}, 32'h1);
        cyc();
        req = 4'b0000;

        // Reset in the middle of a grant to requester 3.
        set_lane(3, 8'hFF);
        req = 4'b1000;
        cyc();
        chk("mid_gnt", {28'd0, gnt}, 32'h8);
        rst = 1'b1;
        cyc();
        chk("mid_rst_gnt", {28'd0, gnt}, 32'h0);
        chk("mid_rst_ack", {28'd0, ack}, 32'h0);
        chk("mid_rst_q",   {24'd0, q},   32'h0);
        rst = 1'b0;
        req = 4'b0000;
        cyc();
        chk("after_rst_ack", {28'd0, ack}, 32'h0);
        chk("after_rst_q",   {24'd0, q},   32'h0);

        // ptr back at 0: requester 1 wins over 2.
        req = 4'b0110;
        push(1, 8'h77);
        cyc();
        chk("ptr_reset_gnt", {28'd0, gnt}, 32'h2);
        cyc();
        req = 4'b0000;
        cyc();

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_reg_wr_arbiter
`default_nettype wire

// File: doc/reg_wr_arbiter.md
REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the register; legal range 2..8.
REQ-002 Parameter WIDTH, default 8: width of the shared register and of each write-data lane.
REQ-003 Port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1: synchronous, active-high reset, sampled on posedge clk.
REQ-005 Port req, input, NREQ: per-requester write request; requester i holds req[i] and its wdata lane until ack[i].
REQ-006 Port wdata, input, NREQ*WIDTH: lane i at bits [i*WIDTH +: WIDTH].
REQ-007 Port gnt, output, NREQ: registered one-hot grant; all zero when no grant is active.
REQ-008 Port ack, output, NREQ: registered one-cycle pulse marking the write completion for requester i.
REQ-009 Port q, output, WIDTH: shared register contents.
REQ-010 Port busy, output, 1: high whenever the FSM is in GRANT.

Function
REQ-011 FSM states: IDLE and GRANT only; each state lasts exactly one cycle per transaction step.
REQ-012 IDLE: eligible = req & ~ack; if eligible is nonzero, register winner into gnt and go to GRANT; else stay in IDLE with gnt = 0.
REQ-013 Winner: first set bit of eligible searched upward from index ptr, wrapping from NREQ-1 to 0.
REQ-014 GRANT with req[winner]=1: q <= wdata lane of winner; ack[winner] <= 1; ptr <= (winner+1) mod NREQ; gnt <= 0; go to IDLE.
REQ-015 GRANT with req[winner]=0 (abort): q, ptr unchanged; no ack; gnt <= 0; go to IDLE.
REQ-016 Latency: req rising before edge N (FSM in IDLE) -> gnt high cycle N+1 -> q and ack updated at edge N+2; 2 cycles request-to-write.
REQ-017 Back-to-back: an arbiter with continuous requests completes one write every 2 cycles; no idle cycle is inserted beyond IDLE.
REQ-018 ack masking: a requester whose ack is high in the current cycle is not eligible in that cycle, even if req still high.
REQ-019 Fairness: with all NREQ requesting continuously, each requester is served exactly once per NREQ writes.
REQ-020 Changes on non-granted lanes, or on req of non-granted requesters during GRANT, have no effect on q, gnt or ack.
REQ-021 ack is at most one-hot; gnt and ack are never both nonzero in the same cycle.
REQ-022 ptr wraps from NREQ-1 to 0 without a skipped or repeated index.

Reset
REQ-023 On rst=1 at posedge: state <= IDLE, gnt <= 0, ack <= 0, q <= 0, ptr <= 0, busy low next cycle.
REQ-024 rst dominates every other input in the same cycle, including a GRANT in progress; the interrupted write does not occur and no ack is issued.
REQ-025 First cycle after rst deasserts is an ordinary IDLE cycle; requests present are arbitrated normally.

Structure
REQ-026 Package reg_arb_pkg holds the state enum (IDLE, GRANT) and the default NREQ/WIDTH constants.
REQ-027 One sub-module rr_pick: combinational round-robin picker, inputs eligible[NREQ] and ptr, outputs one-hot winner and its index, plus valid.
REQ-028 q, gnt, ack, ptr and state are the only sequential elements; no latches and no combinational path from req or wdata to any output.

Verification
REQ-029 Reset: drive rst=1 for 2 cycles with req=4'b1111 -> q=0, gnt=0, ack=0, busy=0 throughout; after release, gnt=4'b0001 one cycle later.
REQ-030 Single write: req[2]=1, lane2=8'hA5 -> gnt=4'b0100 for 1 cycle, then q=8'hA5 and ack=4'b0100 for 1 cycle; ptr=3.
REQ-031 Round robin: req=4'b1111 held continuously, lanes 8'h10..8'h13 -> ack order 0,1,2,3,0, q sequence 10,11,12,13,10, one write every 2 cycles.
REQ-032 Wrap and skip: ptr=3, req=4'b0011 -> requester 0 granted first, then 1; requester 3 never granted.
REQ-033 Abort: req[1] dropped while gnt=4'b0010 -> no ack, q unchanged, ptr unchanged, FSM back in IDLE next cycle.
REQ-034 Reset mid-operation: assert rst while gnt=4'b1000 with lane3=8'hFF -> q=0, no ack[3] pulse, gnt=0 next cycle.
